// File: rtl/ctrl_decode_pkg.sv
// ctrl_decode_pkg
//   Shared encodings for the multicycle ARM control unit: 4-bit main-FSM
//   state codes, datapath mux select codes, ALU control codes, data-processing
//   command codes, and the cmd -> ALUControl decode helper.
package ctrl_decode_pkg;

  // Main FSM state encodings (kept as plain 4-bit constants so existing
  // waveform decoders and probes that expect these values keep working).
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_UNDEF  = 4'd10;

  // Instruction class (Instr[27:26])
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // ALUSrcB select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUControl codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Unsupported commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] ctl;
    case (cmd)
      CMD_ADD: ctl = ALU_ADD;
      CMD_SUB: ctl = ALU_SUB;
      CMD_AND: ctl = ALU_AND;
      CMD_ORR: ctl = ALU_ORR;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ctrl_decode_main_fsm.sv
// main_fsm
//   State register, next-state logic and Moore output decode for the
//   multicycle ARM controller. Every output here depends on state only.
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset -> FETCH)
//   Op         in   [1:0] instruction class (Instr[27:26])
//   imm_flag   in   Funct[5], immediate operand (I)
//   load_flag  in   Funct[0], load/store select (L)
//   IRWrite    out  instruction register enable
//   NextPC     out  unconditional PC+4 write
//   AdrSrc     out  0=PC, 1=ALUResult register
//   ALUSrcA    out  0=RD1, 1=PC
//   ALUSrcB    out  [1:0] 00=RD2, 01=ExtImm, 10=const 4
//   ResultSrc  out  [1:0] 00=ALUOut, 01=Data, 10=ALUResult
//   RegW       out  register write request
//   MemW       out  memory write request
//   alu_op     out  1 in EXECUTE states, enables Funct-driven ALU decode
//   branch     out  1 in BRANCH state
//   Undef      out  1 while in UNDEF state
module main_fsm
  import ctrl_decode_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       imm_flag,
  input  logic       load_flag,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       alu_op,
  output logic       branch,
  output logic       Undef
);

  logic [3:0] state;
  logic [3:0] state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:    state_next = S_MEMADR;
          OP_DP:     state_next = imm_flag ? S_EXECI : S_EXECR;
          OP_BRANCH: state_next = S_BRANCH;
          default:   state_next = S_UNDEF;
        endcase
      end
      S_MEMADR: state_next = load_flag ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_next = S_ALUWB;
      S_MEMWB,
      S_MEMWR,
      S_ALUWB,
      S_BRANCH: state_next = S_FETCH;
      S_UNDEF:  state_next = HALT_ON_UNDEF ? S_UNDEF : S_FETCH;
      // Unused encodings drop back to FETCH on the next edge.
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    Undef     = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      S_ALUWB:  RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      S_UNDEF:  Undef = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Multicycle ARM control unit. Wraps the main FSM and adds the ALU decode,
//   PC-source detection and Op-driven immediate/register source selects.
//   Outputs feed the condition-logic stage and the datapath muxes.
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset (0 = reset)
//   Op          in   [1:0] Instr[27:26]
//   Funct       in   [5:0] Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   Rd          in   [3:0] Instr[15:12]
//   FlagW       out  [1:0] [1]=N,Z write, [0]=C,V write
//   PCS         out  PC source is result
//   NextPC      out  unconditional PC+4 write
//   RegW        out  register write request
//   MemW        out  memory write request
//   IRWrite     out  instruction register enable
//   AdrSrc      out  0=PC, 1=ALUResult register
//   ALUSrcA     out  0=RD1, 1=PC
//   ALUSrcB     out  [1:0] 00=RD2, 01=ExtImm, 10=const 4
//   ResultSrc   out  [1:0] 00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc      out  [1:0] equal to Op
//   RegSrc      out  [1:0] [1]=(Op==01), [0]=(Op==10)
//   ALUControl  out  [1:0] 00 ADD, 01 SUB, 10 AND, 11 ORR
//   Undef       out  1 while in UNDEF state
module ctrl_decode
  import ctrl_decode_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic       Undef
);

  logic alu_op;
  logic branch;

  main_fsm #(
    .HALT_ON_UNDEF(HALT_ON_UNDEF)
  ) u_main_fsm (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .imm_flag  (Funct[5]),
    .load_flag (Funct[0]),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .RegW      (RegW),
    .MemW      (MemW),
    .alu_op    (alu_op),
    .branch    (branch),
    .Undef     (Undef)
  );

  // Flag writes are gated by alu_op, so they only occur in EXECUTE and the
  // flags update exactly once per data-processing instruction.
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    if (alu_op) begin
      ALUControl = alu_decode(Funct[4:1]);
      FlagW[1]   = Funct[0];
      FlagW[0]   = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
    end
  end

  // RegW is only high in the writeback states, so a write to R15 there
  // redirects the PC.
  assign PCS    = branch | (RegW & (Rd == 4'hF));
  assign ImmSrc = Op;
  assign RegSrc = {(Op == OP_MEM), (Op == OP_BRANCH)};

endmodule
